// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the MFA/MFC handshake memory
//
// Purpose: access-size encodings, handshake FSM state type, default memory
//          geometry and the alignment helper used by the optional
//          misalignment trap (MISALIGN_TRAP_EN).
// Ports:   none (package).

package mem_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;   // 2'b11 is also decoded as a word

   localparam int MEM_ADDR_W = 9;
   localparam int MEM_DEPTH  = 1 << MEM_ADDR_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } memState_t;

   // Halfwords must be 2-byte aligned, words (size 10 or 11) 4-byte aligned.
   function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLow);
      logic bad;
      bad = 1'b0;
      if (size == SIZE_HALF)
         bad = addrLow[0];
      else if (size != SIZE_BYTE)
         bad = (addrLow != 2'b00);
      return bad;
   endfunction

endpackage

// File: rtl/ram_byte_lanes.sv
// rtl/ram_byte_lanes.sv - big-endian byte lane steering for the handshake memory
//
// Purpose: from the latched address/size/write data, produce the four
//          wrapped byte addresses, per-lane write enables, per-lane write
//          bytes, and the right-justified, zero-extended read merge.
//          Lane i always addresses byte addr+i (mod 2^ADDR_W); lane 0 is the
//          most significant byte of the access.
// Ports:
//   addr        in   latched byte address
//   size        in   latched access size
//   wrData      in   latched write data (right-justified)
//   rdBytes     in   current memory contents at laneAddr[3:0]
//   laneAddr    out  wrapped byte address for each lane
//   laneWe      out  lanes covered by the access size
//   laneWrByte  out  byte to store in each lane
//   rdData      out  merged read data, zero-extended

import mem_pkg::*;

module ram_byte_lanes #(
   parameter int ADDR_W = 9
) (
   input  logic [ADDR_W-1:0]      addr,
   input  logic [1:0]             size,
   input  logic [31:0]            wrData,
   input  logic [3:0][7:0]        rdBytes,
   output logic [3:0][ADDR_W-1:0] laneAddr,
   output logic [3:0]             laneWe,
   output logic [3:0][7:0]        laneWrByte,
   output logic [31:0]            rdData
);

   // Natural ADDR_W-bit overflow gives the modulo-depth wrap.
   always_comb begin
      for (int i = 0; i < 4; i++)
         laneAddr[i] = addr + ADDR_W'(i);
   end

   always_comb begin
      laneWe     = 4'b0000;
      laneWrByte = '0;
      rdData     = '0;
      case (size)
         SIZE_BYTE: begin
            laneWe        = 4'b0001;
            laneWrByte[0] = wrData[7:0];
            rdData        = {24'd0, rdBytes[0]};
         end
         SIZE_HALF: begin
            laneWe        = 4'b0011;
            laneWrByte[0] = wrData[15:8];
            laneWrByte[1] = wrData[7:0];
            rdData        = {16'd0, rdBytes[0], rdBytes[1]};
         end
         default: begin
            laneWe        = 4'b1111;
            laneWrByte[0] = wrData[31:24];
            laneWrByte[1] = wrData[23:16];
            laneWrByte[2] = wrData[15:8];
            laneWrByte[3] = wrData[7:0];
            rdData        = {rdBytes[0], rdBytes[1], rdBytes[2], rdBytes[3]};
         end
      endcase
   end

endmodule

// File: rtl/mem_handshake_ram.sv
// rtl/mem_handshake_ram.sv - byte-addressed main memory on the MFA/MFC handshake
//
// Purpose: latches a request when ramMFA is sampled in IDLE, waits LATENCY
//          cycles, performs the big-endian byte/halfword/word access and
//          holds ramMFC until ramMFA drops. Dropping ramMFA while BUSY aborts
//          with no side effects. Optional misalignment trap under
//          MISALIGN_TRAP_EN adds ramErr and suppresses misaligned accesses.
// Ports:
//   Clk          in   clock, rising edge
//   reset        in   synchronous active-low reset
//   ramMFA       in   memory function active (request)
//   ramRW        in   0 = read, 1 = write
//   ramDataSize  in   00 byte, 01 halfword, 10/11 word
//   ramAddress   in   byte address
//   dataIn       in   write data, right-justified
//   dataOut      out  read data, right-justified, zero-extended
//   ramMFC       out  memory function complete (registered)
//   ramErr       out  misaligned-access flag (MISALIGN_TRAP_EN only)

import mem_pkg::*;

module mem_handshake_ram #(
   parameter int ADDR_W  = MEM_ADDR_W,
   parameter int LATENCY = 2            // 1..15
) (
   input  logic              Clk,
   input  logic              reset,
   input  logic              ramMFA,
   input  logic              ramRW,
   input  logic [1:0]        ramDataSize,
   input  logic [ADDR_W-1:0] ramAddress,
   input  logic [31:0]       dataIn,
   output logic [31:0]       dataOut,
   output logic              ramMFC
`ifdef MISALIGN_TRAP_EN
   ,
   output logic              ramErr
`endif
);

   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   memState_t         state;
   logic [3:0]        cnt;
   logic [ADDR_W-1:0] addrQ;
   logic              rwQ;
   logic [1:0]        sizeQ;
   logic [31:0]       dataQ;

   logic [7:0]        mem [1 << ADDR_W];

   logic [3:0][ADDR_W-1:0] laneAddr;
   logic [3:0]             laneWe;
   logic [3:0][7:0]        laneWrByte;
   logic [3:0][7:0]        rdBytes;
   logic [31:0]            rdMerged;

   logic completing;
   logic trapHit;
   logic commitWrite;

   ram_byte_lanes #(.ADDR_W(ADDR_W)) uLanes (
      .addr       (addrQ),
      .size       (sizeQ),
      .wrData     (dataQ),
      .rdBytes    (rdBytes),
      .laneAddr   (laneAddr),
      .laneWe     (laneWe),
      .laneWrByte (laneWrByte),
      .rdData     (rdMerged)
   );

   always_comb begin
      for (int i = 0; i < 4; i++)
         rdBytes[i] = mem[laneAddr[i]];
   end

   // The single cycle on which an un-aborted access finishes.
   assign completing = (state == BUSY) && ramMFA && (cnt == 4'd0);

`ifdef MISALIGN_TRAP_EN
   assign trapHit = isMisaligned(sizeQ, addrQ[1:0]);
`else
   assign trapHit = 1'b0;
`endif

   assign commitWrite = completing && rwQ && !trapHit;

   always_ff @(posedge Clk) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         ramMFC  <= 1'b0;
         dataOut <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (ramMFA) begin
                  addrQ <= ramAddress;
                  rwQ   <= ramRW;
                  sizeQ <= ramDataSize;
                  dataQ <= dataIn;
                  cnt   <= CNT_LOAD;
                  state <= BUSY;
               end
            end
            BUSY: begin
               // Abort wins over completion on the same edge.
               if (!ramMFA) begin
                  state <= IDLE;
               end else if (cnt == 4'd0) begin
                  state  <= DONE;
                  ramMFC <= 1'b1;
                  if (!rwQ && !trapHit)
                     dataOut <= rdMerged;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            DONE: begin
               // MFA held high here is the tail of the same request.
               if (!ramMFA) begin
                  state  <= IDLE;
                  ramMFC <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Storage is never reset; reset only blocks a pending commit.
   always_ff @(posedge Clk) begin
      if (reset && commitWrite) begin
         for (int i = 0; i < 4; i++)
            if (laneWe[i])
               mem[laneAddr[i]] <= laneWrByte[i];
      end
   end

`ifdef MISALIGN_TRAP_EN
   always_ff @(posedge Clk) begin
      if (!reset)
         ramErr <= 1'b0;
      else if (completing)
         ramErr <= trapHit;
      else if (state == DONE && !ramMFA)
         ramErr <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_mem_handshake_ram.sv
// tb/tb_mem_handshake_ram.sv - directed self-checking bench for mem_handshake_ram

import mem_pkg::*;

module tb_mem_handshake_ram;

   localparam int LAT = 2;
`ifdef MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        Clk = 1'b0;
   logic        reset = 1'b0;
   logic        ramMFA = 1'b0;
   logic        ramRW = 1'b0;
   logic [1:0]  ramDataSize = 2'b00;
   logic [8:0]  ramAddress = '0;
   logic [31:0] dataIn = '0;
   logic [31:0] dataOut;
   logic        ramMFC;
`ifdef MISALIGN_TRAP_EN
   logic        ramErr;
`endif

   int nCompared = 0;
   int nMismatched = 0;

   mem_handshake_ram #(.ADDR_W(9), .LATENCY(LAT)) dut (
      .Clk         (Clk),
      .reset       (reset),
      .ramMFA      (ramMFA),
      .ramRW       (ramRW),
      .ramDataSize (ramDataSize),
      .ramAddress  (ramAddress),
      .dataIn      (dataIn),
      .dataOut     (dataOut),
      .ramMFC      (ramMFC)
`ifdef MISALIGN_TRAP_EN
      ,
      .ramErr      (ramErr)
`endif
   );

   always #5 Clk = ~Clk;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatched++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One full handshake; inputs are scrambled right after the latch edge.
   task automatic memAccess(input string tag, input logic rw, input logic [1:0] sz,
                            input logic [8:0] a, input logic [31:0] d,
                            input int hold, input logic expErr);
      int k;
      ramMFA = 1'b1; ramRW = rw; ramDataSize = sz; ramAddress = a; dataIn = d;
      @(posedge Clk); #1;
      ramRW = ~rw; ramAddress = a ^ 9'h155; dataIn = ~d; ramDataSize = ~sz;
      k = 0;
      while (!ramMFC && k < 20) begin
         @(posedge Clk); #1;
         k++;
      end
      checkVal({tag, ".lat"}, 32'(k), 32'(LAT));
`ifdef MISALIGN_TRAP_EN
      checkVal({tag, ".err"}, {31'd0, ramErr}, {31'd0, expErr});
`endif
      for (int i = 0; i < hold; i++) begin
         @(posedge Clk); #1;
         checkVal({tag, ".hold"}, {31'd0, ramMFC}, 32'd1);
      end
      ramMFA = 1'b0;
      @(posedge Clk); #1;
      checkVal({tag, ".rel"}, {31'd0, ramMFC}, 32'd0);
`ifdef MISALIGN_TRAP_EN
      checkVal({tag, ".errClr"}, {31'd0, ramErr}, 32'd0);
`endif
      if (expErr && !TRAP) checkVal({tag, ".cfg"}, 32'd1, 32'd0);
   endtask

   task automatic readChk(input string tag, input logic [1:0] sz, input logic [8:0] a,
                          input logic [31:0] exp, input logic expErr);
      memAccess(tag, 1'b0, sz, a, 32'h0, 0, expErr);
      checkVal({tag, ".data"}, dataOut, exp);
   endtask

   // MFA raised for one latch edge then dropped while BUSY.
   task automatic abortAccess(input string tag, input logic rw, input logic [8:0] a,
                              input logic [31:0] d);
      ramMFA = 1'b1; ramRW = rw; ramDataSize = SIZE_BYTE; ramAddress = a; dataIn = d;
      @(posedge Clk); #1;
      ramMFA = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge Clk); #1;
         checkVal({tag, ".mfc"}, {31'd0, ramMFC}, 32'd0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      checkVal("rst.mfc", {31'd0, ramMFC}, 32'd0);
      checkVal("rst.dout", dataOut, 32'd0);
`ifdef MISALIGN_TRAP_EN
      checkVal("rst.err", {31'd0, ramErr}, 32'd0);
`endif
      reset = 1'b1;
      @(posedge Clk); #1;

      memAccess("wrWord8", 1'b1, SIZE_WORD, 9'd8, 32'hDEADBEEF, 0, 1'b0);
      readChk("rdByte9", SIZE_BYTE, 9'd9, 32'h000000AD, 1'b0);

      memAccess("wrWord4", 1'b1, SIZE_WORD, 9'd4, 32'hAABBCCDD, 0, 1'b0);
      memAccess("wrHalf4", 1'b1, SIZE_HALF, 9'd4, 32'hFFFF1234, 0, 1'b0);
      readChk("rdWord4", SIZE_WORD, 9'd4, 32'h1234CCDD, 1'b0);
      readChk("rdHalf6", SIZE_HALF, 9'd6, 32'h0000CCDD, 1'b0);
      readChk("rdSize3", 2'b11, 9'd8, 32'hDEADBEEF, 1'b0);

      memAccess("wrB510", 1'b1, SIZE_BYTE, 9'd510, 32'h123456AA, 0, 1'b0);
      memAccess("wrB511", 1'b1, SIZE_BYTE, 9'd511, 32'h000000BB, 0, 1'b0);
      memAccess("wrB0",   1'b1, SIZE_BYTE, 9'd0,   32'h000000CC, 0, 1'b0);
      memAccess("wrB1",   1'b1, SIZE_BYTE, 9'd1,   32'h000000DD, 0, 1'b0);
      memAccess("wrWrap", 1'b1, SIZE_WORD, 9'd510, 32'h01020304, 0, TRAP);
      readChk("rdWrap510", SIZE_BYTE, 9'd510, TRAP ? 32'hAA : 32'h01, 1'b0);
      readChk("rdWrap511", SIZE_BYTE, 9'd511, TRAP ? 32'hBB : 32'h02, 1'b0);
      readChk("rdWrap0",   SIZE_BYTE, 9'd0,   TRAP ? 32'hCC : 32'h03, 1'b0);
      readChk("rdWrap1",   SIZE_BYTE, 9'd1,   TRAP ? 32'hDD : 32'h04, 1'b0);
      readChk("rdWordWrap", SIZE_WORD, 9'd510, TRAP ? 32'h000000DD : 32'h01020304, TRAP);

      memAccess("hold", 1'b1, SIZE_BYTE, 9'd20, 32'h0000005A, 5, 1'b0);
      readChk("rdHold", SIZE_BYTE, 9'd20, 32'h0000005A, 1'b0);

      abortAccess("abortRd", 1'b0, 9'd8, 32'h0);
      checkVal("abortRd.dout", dataOut, 32'h0000005A);
      abortAccess("abortWr", 1'b1, 9'd20, 32'h00000099);
      readChk("rdAbort", SIZE_BYTE, 9'd20, 32'h0000005A, 1'b0);

      memAccess("wrWord0", 1'b1, SIZE_WORD, 9'd0, 32'h11223344, 0, 1'b0);
      ramMFA = 1'b1; ramRW = 1'b1; ramDataSize = SIZE_WORD; ramAddress = 9'd0; dataIn = 32'hFFFFFFFF;
      @(posedge Clk); #1;
      repeat (LAT - 1) begin
         @(posedge Clk); #1;
      end
      reset = 1'b0;
      @(posedge Clk); #1;
      checkVal("rstBusy.mfc", {31'd0, ramMFC}, 32'd0);
      checkVal("rstBusy.dout", dataOut, 32'd0);
`ifdef MISALIGN_TRAP_EN
      checkVal("rstBusy.err", {31'd0, ramErr}, 32'd0);
`endif
      reset = 1'b1;
      ramMFA = 1'b0;
      @(posedge Clk); #1;
      readChk("rdAfterRst", SIZE_WORD, 9'd0, 32'h11223344, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
